// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer arithmetic shared by the write-side and read-side
// pointer blocks of the dual-pointer FIFO.
//   ptr_t      - widest pointer any instance may use (MAX_ALEN+1 bits);
//                instances zero-extend their ALEN+1 bit pointers into it
//   ptr_mask   - keeps only the ALEN+1 bits that belong to a given instance
//   ptr_level  - fill level wptr - rptr, modulo 2**(ALEN+1)
//   ptr_full   - true when fewer than incr free entries remain
package fifo_pkg;

  localparam int unsigned MAX_ALEN = 16;

  typedef logic [MAX_ALEN:0] ptr_t;

  // Mask for an ALEN+1 bit pointer held in a ptr_t.
  function automatic ptr_t ptr_mask(input int unsigned alen);
    return (ptr_t'(1) << (alen + 1)) - ptr_t'(1);
  endfunction

  // Unsigned modulo difference; the mask gives the natural ALEN+1 bit wrap.
  function automatic ptr_t ptr_level(input ptr_t wptr, input ptr_t rptr,
                                     input int unsigned alen);
    return (wptr - rptr) & ptr_mask(alen);
  endfunction

  // Full when a further step of incr entries would not fit.
  function automatic logic ptr_full(input ptr_t level, input int unsigned incr,
                                    input int unsigned depth);
    return level > ptr_t'(depth - incr);
  endfunction

endpackage

// File: rtl/wr_ptr.sv
// wr_ptr: write-side pointer controller of the dual-pointer FIFO.
// Accepts an AXI-Stream style slave handshake, drives the RAM write port,
// publishes the binary write pointer (MSB = wrap bit) to the read side and
// produces full / almost-full / level / high-watermark status.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   i_tvalid      upstream beat valid
//   o_tready      registered; room for at least INCR entries
//   o_wen         RAM write enable (i_tvalid & o_tready)
//   o_waddr       RAM write address (o_wptr without the wrap bit)
//   o_wptr        registered write pointer, ALEN+1 bits
//   i_rptr        read pointer from the read side, same clock domain
//   o_level       registered fill level
//   o_afull       registered; o_level >= AFULL_THRESH
//   o_hwm         registered maximum o_level since reset / clear
//   i_hwm_clr     synchronous clear of o_hwm
module wr_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ALEN         = 8,
  parameter int unsigned INCR         = 1,
  parameter int unsigned AFULL_THRESH = 2**ALEN - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tvalid,
  output logic            o_tready,
  output logic            o_wen,
  output logic [ALEN-1:0] o_waddr,
  output logic [ALEN:0]   o_wptr,
  input  logic [ALEN:0]   i_rptr,
  output logic [ALEN:0]   o_level,
  output logic            o_afull,
  output logic [ALEN:0]   o_hwm,
  input  logic            i_hwm_clr
);

  localparam int unsigned DEPTH = 2**ALEN;
  localparam int unsigned PW    = ALEN + 1;

  typedef logic [ALEN:0] wptr_t;

  localparam wptr_t INCR_P   = wptr_t'(INCR);
  localparam wptr_t AFULL_P  = wptr_t'(AFULL_THRESH);
  localparam wptr_t DEPTH_P  = wptr_t'(DEPTH);

  wptr_t wptr_d;
  wptr_t level_d;
  logic  full_d;
  logic  afull_d;
  wptr_t hwm_d;
  wptr_t cur_level;

  assign o_wen   = i_tvalid & o_tready;
  assign o_waddr = o_wptr[ALEN-1:0];

  always_comb begin
    wptr_d  = o_wen ? o_wptr + INCR_P : o_wptr;
    // Status is computed from the post-write pointer so that the beat that
    // fills the last slot drops o_tready on the very next cycle.
    level_d = PW'(ptr_level(ptr_t'(wptr_d), ptr_t'(i_rptr), ALEN));
    full_d  = ptr_full(ptr_t'(level_d), INCR, DEPTH);
    afull_d = level_d >= AFULL_P;
    if (i_hwm_clr)
      hwm_d = level_d;
    else
      hwm_d = (level_d > o_hwm) ? level_d : o_hwm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_wptr   <= '0;
      o_tready <= 1'b0;
      o_level  <= '0;
      o_afull  <= 1'b0;
      o_hwm    <= '0;
    end else begin
      o_wptr   <= wptr_d;
      o_tready <= ~full_d;
      o_level  <= level_d;
      o_afull  <= afull_d;
      o_hwm    <= hwm_d;
    end
  end

  // The read pointer must never run ahead of, or lag more than DEPTH
  // behind, the write pointer.
  assign cur_level = PW'(ptr_level(ptr_t'(o_wptr), ptr_t'(i_rptr), ALEN));

  a_legal_rptr: assert property (@(posedge clk) disable iff (rst)
    cur_level <= DEPTH_P);

endmodule

// File: tb/tb_wr_ptr.sv
module tb_wr_ptr;

  logic       clk;
  logic       rst   [2];
  logic       tv    [2];
  logic       clr   [2];
  logic [3:0] rptr  [2];
  logic       tready[2];
  logic       wen   [2];
  logic       afull [2];
  logic [2:0] waddr [2];
  logic [3:0] wptr  [2];
  logic [3:0] level [2];
  logic [3:0] hwm   [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wr_ptr #(.ALEN(3), .INCR(1), .AFULL_THRESH(6)) dut_a (
    .clk(clk), .rst(rst[0]), .i_tvalid(tv[0]), .o_tready(tready[0]),
    .o_wen(wen[0]), .o_waddr(waddr[0]), .o_wptr(wptr[0]), .i_rptr(rptr[0]),
    .o_level(level[0]), .o_afull(afull[0]), .o_hwm(hwm[0]),
    .i_hwm_clr(clr[0])
  );

  wr_ptr #(.ALEN(3), .INCR(2), .AFULL_THRESH(6)) dut_b (
    .clk(clk), .rst(rst[1]), .i_tvalid(tv[1]), .o_tready(tready[1]),
    .o_wen(wen[1]), .o_waddr(waddr[1]), .o_wptr(wptr[1]), .i_rptr(rptr[1]),
    .o_level(level[1]), .o_afull(afull[1]), .o_hwm(hwm[1]),
    .i_hwm_clr(clr[1])
  );

  typedef struct {
    int dut;
    int wptr;
    int tready;
    int level;
    int afull;
    int hwm;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  int incr_of [2];
  int m_wptr  [2];
  int m_tready[2];
  int m_level [2];
  int m_afull [2];
  int m_hwm   [2];
  bit m_init  [2];
  bit last_wen[2];
  int last_waddr[2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next-state reference for one DUT, from the inputs it sees at this edge.
  function automatic exp_t model_edge(input int d);
    exp_t e;
    int w, nw, lv;
    e.dut = d;
    if (rst[d]) begin
      e.wptr = 0; e.tready = 0; e.level = 0; e.afull = 0; e.hwm = 0;
    end else begin
      w  = (tv[d] && m_tready[d] != 0) ? 1 : 0;
      nw = (m_wptr[d] + (w != 0 ? incr_of[d] : 0)) % 16;
      lv = (nw - int'(rptr[d]) + 16) % 16;
      e.wptr   = nw;
      e.level  = lv;
      e.tready = (lv > 8 - incr_of[d]) ? 0 : 1;
      e.afull  = (lv >= 6) ? 1 : 0;
      e.hwm    = clr[d] ? lv : ((lv > m_hwm[d]) ? lv : m_hwm[d]);
    end
    return e;
  endfunction

  // One clock: check combinational outputs, push expectations, take the
  // edge, then pop and compare the registered outputs.
  task automatic step();
    exp_t e;
    int d;
    #1;
    for (int k = 0; k < 2; k++) begin
      last_wen[k]   = wen[k];
      last_waddr[k] = int'(waddr[k]);
      if (m_init[k]) begin
        check_eq($sformatf("wen[%0d]", k), int'(wen[k]),
                 (tv[k] && m_tready[k] != 0) ? 1 : 0);
        if (wen[k])
          check_eq($sformatf("waddr[%0d]", k), int'(waddr[k]), m_wptr[k] % 8);
      end
      e = model_edge(k);
      if (rst[k]) m_init[k] = 1'b1;
      m_wptr[k]   = e.wptr;
      m_tready[k] = e.tready;
      m_level[k]  = e.level;
      m_afull[k]  = e.afull;
      m_hwm[k]    = e.hwm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.dut;
      check_eq($sformatf("wptr[%0d]", d),   int'(wptr[d]),   e.wptr);
      check_eq($sformatf("tready[%0d]", d), int'(tready[d]), e.tready);
      check_eq($sformatf("level[%0d]", d),  int'(level[d]),  e.level);
      check_eq($sformatf("afull[%0d]", d),  int'(afull[d]),  e.afull);
      check_eq($sformatf("hwm[%0d]", d),    int'(hwm[d]),    e.hwm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int wraps;
    incr_of[0] = 1;
    incr_of[1] = 2;
    for (int d = 0; d < 2; d++) begin
      m_wptr[d] = 0; m_tready[d] = 0; m_level[d] = 0;
      m_afull[d] = 0; m_hwm[d] = 0; m_init[d] = 1'b0;
      rst[d] = 1'b1; clr[d] = 1'b0; rptr[d] = 4'd0;
    end
    tv[0] = 1'b1;
    tv[1] = 1'b0;

    // Reset held with i_tvalid high
    repeat (3) step();
    #1;
    check_eq("rst_wen", int'(wen[0]), 0);
    check_eq("rst_tready", int'(tready[0]), 0);
    check_eq("rst_wptr", int'(wptr[0]), 0);
    check_eq("rst_hwm", int'(hwm[0]), 0);

    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();
    check_eq("tready_rise", int'(tready[0]), 1);
    check_eq("tready_rise_nowen", int'(last_wen[0]), 0);

    // Fill from empty with the reader stalled
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_wen[0]) begin
        check_eq("fill_waddr", last_waddr[0], n);
        n++;
        if (n == 5) check_eq("afull_after5", int'(afull[0]), 0);
        if (n == 6) check_eq("afull_after6", int'(afull[0]), 1);
      end
    end
    check_eq("fill_beats", n, 8);
    check_eq("fill_wptr", int'(wptr[0]), 8);
    check_eq("fill_level", int'(level[0]), 8);
    check_eq("fill_tready", int'(tready[0]), 0);

    // One read reopens the write side a cycle later
    rptr[0] = 4'd1;
    step();
    check_eq("reopen_nowen", int'(last_wen[0]), 0);
    check_eq("reopen_tready", int'(tready[0]), 1);
    step();
    check_eq("reopen_wen", int'(last_wen[0]), 1);
    check_eq("reopen_waddr", last_waddr[0], 0);
    check_eq("reopen_wptr", int'(wptr[0]), 9);
    check_eq("reopen_level", int'(level[0]), 8);
    check_eq("reopen_tready_drop", int'(tready[0]), 0);
    tv[0] = 1'b0;

    // Pointer wrap with a write and a read every cycle at level 2
    rptr[0] = 4'd7;
    step();
    check_eq("wrap_start_level", int'(level[0]), 2);
    tv[0] = 1'b1;
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      rptr[0] = rptr[0] + 4'd1;
      step();
      check_eq("wrap_level", int'(level[0]), 2);
      check_eq("wrap_afull", int'(afull[0]), 0);
      check_eq("wrap_tready", int'(tready[0]), 1);
      if (last_wen[0] && last_waddr[0] == 7) begin
        wraps++;
        check_eq("wrap_wptr", int'(wptr[0]), 0);
        check_eq("wrap_waddr", int'(waddr[0]), 0);
      end
    end
    check_eq("wrap_count", wraps, 1);
    check_eq("wrap_end_wptr", int'(wptr[0]), 1);
    tv[0] = 1'b0;

    // High watermark: clear, fill to 5, drain to 1, clear with a write
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check_eq("hwm_clear_idle", int'(hwm[0]), 2);
    tv[0] = 1'b1;
    repeat (3) step();
    tv[0] = 1'b0;
    check_eq("hwm_fill_level", int'(level[0]), 5);
    for (int i = 0; i < 4; i++) begin
      rptr[0] = rptr[0] + 4'd1;
      step();
    end
    check_eq("hwm_drain_level", int'(level[0]), 1);
    check_eq("hwm_before_clr", int'(hwm[0]), 5);
    clr[0] = 1'b1;
    tv[0]  = 1'b1;
    step();
    clr[0] = 1'b0;
    tv[0]  = 1'b0;
    check_eq("hwm_after_clr", int'(hwm[0]), 2);
    check_eq("hwm_clr_level", int'(level[0]), 2);

    // INCR=2: fill until full
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    tv[1]  = 1'b1;
    step();
    for (int i = 0; i < 8 && level[1] != 4'd8; i++) begin
      step();
      if (level[1] == 4'd6) check_eq("b_level6_tready", int'(tready[1]), 1);
    end
    check_eq("b_full_level", int'(level[1]), 8);
    check_eq("b_full_tready", int'(tready[1]), 0);
    step();
    check_eq("b_no_overrun", int'(last_wen[1]), 0);

    // INCR=2: reset in the middle of a burst at level 4
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    repeat (3) step();
    check_eq("b_mid_level", int'(level[1]), 4);
    rst[1] = 1'b1;
    step();
    check_eq("b_rst_wptr", int'(wptr[1]), 0);
    check_eq("b_rst_level", int'(level[1]), 0);
    check_eq("b_rst_tready", int'(tready[1]), 0);
    check_eq("b_rst_afull", int'(afull[1]), 0);
    check_eq("b_rst_hwm", int'(hwm[1]), 0);
    rst[1] = 1'b0;
    tv[1]  = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
